// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction/PC buffer between fetch and decode; FETCH_QUEUE_PREDECODE_EN adds branch/jump class bits
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic [31:0]   in_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic [31:0]   out_pc,
   output logic          out_is_branch,
   output logic          out_is_jump,
   input  logic          flush,
   output logic [CW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   r_instr [DEPTH];
   logic [31:0]   r_pc    [DEPTH];
   logic [AW-1:0] r_head, r_tail;
   logic [CW-1:0] r_count;
   logic          w_enq, w_deq;
   assign in_ready  = r_count != CW'(DEPTH);
   assign out_valid = r_count != '0;
   assign w_enq     = in_valid && in_ready && !flush;
   assign w_deq     = out_valid && out_ready;
   assign count     = r_count;
   assign out_instr = out_valid ? r_instr[r_head] : '0;
   assign out_pc    = out_valid ? r_pc[r_head] : '0;
   // storage is left uncleared by reset; only accepted pairs are written
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_instr[r_tail] <= in_instr;
         r_pc[r_tail]    <= in_pc;
      end
   end
   // pointers and occupancy; flush empties the queue and drops any same-cycle enqueue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_tail  <= w_enq ? r_tail + 1'b1 : r_tail;
         r_head  <= w_deq ? r_head + 1'b1 : r_head;
         r_count <= (w_enq && !w_deq) ? r_count + 1'b1 : (!w_enq && w_deq) ? r_count - 1'b1 : r_count;
      end
   end
`ifdef FETCH_QUEUE_PREDECODE_EN
   logic [1:0] r_cls [DEPTH];
   logic [1:0] w_cls;
   logic [5:0] w_op, w_fn;
   assign w_op  = in_instr[31:26];
   assign w_fn  = in_instr[5:0];
   assign w_cls = {(w_op == 6'b000010) || (w_op == 6'b000011) || (w_op == 6'b000000 && w_fn == 6'b001000),
                   (w_op == 6'b000100) || (w_op == 6'b000101)};
   // class bits are computed once at enqueue so decode sees them with the head entry
   always_ff @(posedge clk) begin
      if (w_enq) r_cls[r_tail] <= w_cls;
   end
   assign out_is_branch = out_valid && r_cls[r_head][0];
   assign out_is_jump   = out_valid && r_cls[r_head][1];
`else
   assign out_is_branch = 1'b0;
   assign out_is_jump   = 1'b0;
`endif
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch buffer between the fetch stage (PC register plus instruction memory) and the decode/controller stage of the MIPS datapath. It accepts one {instruction, PC} pair per cycle from fetch over a valid/ready handshake and holds it in a small circular FIFO. It presents the oldest pair to decode. Decode can stall without losing fetched instructions, and a redirect (branch/jump taken) can discard everything in flight.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: width of `count`. Derived; do not override.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch presents a valid pair.
- `in_ready` out 1: queue can accept a pair this cycle.
- `in_instr` in 32: fetched instruction word.
- `in_pc` in 32: byte address of `in_instr`.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: decode consumes the head this cycle.
- `out_instr` out 32: head instruction; 32'h0000_0000 (nop) when empty.
- `out_pc` out 32: head PC; 32'h0000_0000 when empty.
- `out_is_branch` out 1: head is beq/bne (see Configuration).
- `out_is_jump` out 1: head is j/jal/jr (see Configuration).
- `flush` in 1: discard all entries (redirect).
- `count` out CW: number of valid entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {instr, pc[, class]}.
- Pointers: head and tail, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
- `count` register: CW bits.
- Enqueue occurs when `in_valid && in_ready`: write at tail, tail+1.
- Dequeue occurs when `out_valid && out_ready`: head+1.
- `in_ready = (count != DEPTH)`. It depends on registered state only, never on `out_ready`.
- `out_valid = (count != 0)`. `out_*` data is read combinationally from the head entry and masked to 0 when empty.
- Count update:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue.
- Full with `out_ready=1`: no enqueue that cycle (`in_ready=0`). Dequeue proceeds, and count becomes DEPTH−1.
- Empty with `in_valid=1`: no bypass. The entry becomes visible at `out_*` the next cycle.
- `flush` (synchronous) has priority over everything:
  - head, tail and count all go to 0 at the next edge.
  - A same-cycle enqueue is dropped.
  - A same-cycle dequeue is irrelevant.
  - `in_ready` and `out_valid` still reflect pre-flush state during the flush cycle.
- Asynchronous reset:
  - head = tail = count = 0 immediately.
  - Outputs: `in_ready=1`, `out_valid=0`, `out_instr=0`, `out_pc=0`, `out_is_branch=0`, `out_is_jump=0`, `count=0`.
  - Storage contents are not cleared. Reset mid-operation discards all entries.
- Invariant: tail − head ≡ count (mod DEPTH). Count never exceeds DEPTH and never underflows.

## Timing
- Enqueue-to-output latency: 1 cycle. Data written at edge N is visible at `out_*` after edge N.
- Throughput: 1 pair/cycle sustained when not full.
- No combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.
- Flush takes effect at the edge it is sampled. First post-flush enqueue is accepted in the cycle after the flush.

## Configuration
- Macro: `FETCH_QUEUE_PREDECODE_EN`.
- Defined:
  - Each entry stores a 2-bit class computed at enqueue from `in_instr`.
  - branch: opcode 6'b000100 or 6'b000101.
  - jump: opcode 6'b000010 or 6'b000011, or opcode 0 with funct 6'b001000.
  - `out_is_branch` / `out_is_jump` are driven from the stored head class, masked to 0 when empty.
- Undefined:
  - No class storage.
  - `out_is_branch = out_is_jump = 0` constantly.
  - All other behaviour is identical.

## Test plan
- Reset then idle:
  - `count=0`, `out_valid=0`, `in_ready=1`, `out_instr=0`, `out_pc=0`.
  - Assert reset between edges: outputs return to these values before the next edge.
- Fill with `out_ready=0`: push pcs 0x3000, 0x3004, 0x3008, 0x300c.
  - `count=4`, `in_ready=0`, `out_pc=0x3000`.
  - Fifth `in_valid` is ignored, and count stays 4.
- Drain in order: from full, hold `out_ready=1`.
  - `out_pc` is 0x3000, 0x3004, 0x3008, 0x300c on successive cycles, then `out_valid=0`.
- Streaming with wrap-around: `in_valid=out_ready=1` for 10 cycles, pcs 0x3000+4k.
  - After the first-cycle latency, count stays 1.
  - Output order matches input across pointer wrap.
- Flush with simultaneous enqueue: 3 entries held; assert `flush` with `in_valid=1`, pc 0x3040.
  - Next cycle: `count=0`, `out_valid=0`. 0x3040 is never output.
- Predecode (macro defined): enqueue 0x10220003 (beq), 0x0c000c00 (jal), 0x03e00008 (jr), 0x00221821 (addu).
  - (branch, jump) = (1,0), (0,1), (0,1), (0,0).
  - With the macro undefined, all are (0,0).
